// File: rtl/order_tracker.sv
// ---------------------------------------------------------------------------
// order_tracker
//
// Order queue and scoreboard for the game controller. Timed orders are
// spawned at a fixed interval and held in a compacted queue, oldest first.
// Each order counts down in seconds. A finished dish placed on one of the two
// serving-counter cells is scored against the oldest order. The action block
// is then asked to empty that cell. An order that runs out of time expires
// and costs a penalty. Everything is frozen while timer_go is low.
//
// All state advances once per video frame, on the falling edge of vsync.
//
// Ports
//   vsync         in   1           frame clock; registers update on negedge
//   reset         in   1           synchronous, active-high
//   timer_go      in   1           1 = game running, 0 = hold all state
//   check_spaces  in   [1:0][3:0]  serving cells: [0]=grid[4][12], [1]=grid[5][12]
//   clear_space   out  [1:0]       one-frame request to empty a served cell
//   point_total   out  10          score, 0..MAX_POINTS
//   orders        out  4           active order count, 0..MAX_ORDERS
//   order_times   out  [3:0][4:0]  seconds left per slot, slot 0 = oldest,
//                                  unused slots read 0
// ---------------------------------------------------------------------------
module order_tracker #(
  parameter int         FRAMES_PER_SEC = 60,
  parameter int         ORDER_TIME     = 30,
  parameter int         ORDER_INTERVAL = 10,
  parameter int         MAX_ORDERS     = 4,
  parameter logic [3:0] DISH_CODE      = 4'd7,
  parameter int         BASE_POINTS    = 20,
  parameter int         PENALTY        = 10,
  parameter int         MAX_POINTS     = 999,
  parameter int         HOLDOFF        = 2
) (
  input  logic            vsync,
  input  logic            reset,
  input  logic            timer_go,
  input  logic [1:0][3:0] check_spaces,
  output logic [1:0]      clear_space,
  output logic [9:0]      point_total,
  output logic [3:0]      orders,
  output logic [3:0][4:0] order_times
);

  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam int SW = (ORDER_INTERVAL > 1) ? $clog2(ORDER_INTERVAL) : 1;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [2:0]  MAX_N      = 3'(MAX_ORDERS);
  localparam logic [10:0] MAX_PTS_W  = 11'(MAX_POINTS);
  localparam logic [10:0] PENALTY_W  = 11'(PENALTY);
  localparam logic [10:0] BASE_PTS_W = 11'(BASE_POINTS);

  // Delivery handshake: IDLE looks for a dish, ACK drives the clear pulse,
  // HOLD ignores the counter while the action block empties the cell.
  typedef enum logic [1:0] {
    IDLE,
    ACK,
    HOLD
  } dlv_state_t;

  // Registered state
  dlv_state_t      state_q;
  logic [FW-1:0]   frame_q;
  logic [SW-1:0]   spawn_q;
  logic [HW-1:0]   hold_q;
  logic [2:0]      count_q;
  logic [3:0][4:0] times_q;
  logic [9:0]      points_q;
  logic [1:0]      clear_q;

  // Next-state values
  dlv_state_t      state_d;
  logic [FW-1:0]   frame_d;
  logic [SW-1:0]   spawn_d;
  logic [HW-1:0]   hold_d;
  logic [2:0]      count_d;
  logic [3:0][4:0] times_d;
  logic [9:0]      points_d;
  logic [1:0]      clear_d;

  // Per-frame events
  logic            sec_tick;
  logic            spawn_wrap;
  logic            serve0;
  logic            serve1;
  logic            served;

  // Working copies used to apply the same-frame events in order
  logic [3:0][4:0] times_w;
  logic [2:0]      count_w;
  logic [10:0]     pts_w;
  logic [4:0]      pre0;

  // Drop slot 0 and move every younger order one slot towards the head.
  function automatic logic [3:0][4:0] shift_down(input logic [3:0][4:0] t);
    return {5'd0, t[3:1]};
  endfunction

  // -------------------------------------------------------------------------
  // Second and spawn timers
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    sec_tick   = (frame_q == FW'(FRAMES_PER_SEC - 1));
    frame_d    = sec_tick ? '0 : frame_q + 1'b1;
    spawn_wrap = sec_tick && (spawn_q == SW'(ORDER_INTERVAL - 1));
    spawn_d    = spawn_q;
    if (sec_tick) begin
      spawn_d = spawn_wrap ? '0 : spawn_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Delivery detection and handshake FSM
  // -------------------------------------------------------------------------
  // A dish only counts when there is an order to charge it to; otherwise it
  // stays on the counter untouched. Space 0 wins a tie.
  assign serve0 = (state_q == IDLE) && (count_q != 3'd0) &&
                  (check_spaces[0] == DISH_CODE);
  assign serve1 = (state_q == IDLE) && (count_q != 3'd0) &&
                  (check_spaces[1] == DISH_CODE) && !serve0;
  assign served = serve0 | serve1;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    clear_d = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (served) begin
          state_d = ACK;
          clear_d = {serve1, serve0};
        end
      end
      ACK: begin
        state_d = HOLD;
        hold_d  = HW'(HOLDOFF - 1);
      end
      HOLD: begin
        // The ACK frame already counts as the first ignored frame, so HOLD
        // returns to IDLE on the frame its count would reach zero.
        if (hold_q <= HW'(1)) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Queue and score update. Same-frame events are applied in a fixed order:
  // delivery, decrement, expiry of the new head, spawn at the tail.
  // -------------------------------------------------------------------------
  always_comb begin
    times_w = times_q;
    count_w = count_q;
    pts_w   = {1'b0, points_q};

    // 1. Delivery is scored with the head's pre-decrement time and removes
    //    the head, so that order can never also expire this frame.
    if (served) begin
      pts_w = pts_w + BASE_PTS_W + {6'd0, times_q[0]};
      if (pts_w > MAX_PTS_W) begin
        pts_w = MAX_PTS_W;
      end
      times_w = shift_down(times_w);
      count_w = count_w - 3'd1;
    end

    pre0 = times_w[0];

    // 2. One second off every active order that still has time left.
    if (sec_tick) begin
      for (int i = 0; i < 4; i++) begin
        if ((3'(i) < count_w) && (times_w[i] != 5'd0)) begin
          times_w[i] = times_w[i] - 5'd1;
        end
      end
    end

    // 3. Orders are spawned in age order with the same start time, so only
    //    the head can be the one already sitting at zero.
    if (sec_tick && (count_w != 3'd0) && (pre0 == 5'd0)) begin
      times_w = shift_down(times_w);
      count_w = count_w - 3'd1;
      pts_w   = (pts_w >= PENALTY_W) ? pts_w - PENALTY_W : 11'd0;
    end

    // 4. A spawn that finds the queue full is simply dropped.
    if (spawn_wrap && (count_w < MAX_N)) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) == count_w) begin
          times_w[i] = 5'(ORDER_TIME);
        end
      end
      count_w = count_w + 3'd1;
    end

    times_d  = times_w;
    count_d  = count_w;
    points_d = pts_w[9:0];
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(negedge vsync) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of block order.
    if (reset) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      spawn_q  <= SW'(ORDER_INTERVAL - 1);
      hold_q   <= '0;
      count_q  <= 3'd0;
      times_q  <= '0;
      points_q <= 10'd0;
      clear_q  <= 2'b00;
    end else if (timer_go) begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      spawn_q  <= spawn_d;
      hold_q   <= hold_d;
      count_q  <= count_d;
      times_q  <= times_d;
      points_q <= points_d;
      clear_q  <= clear_d;
    end
  end

  // A frozen game must never ask the action block to touch the grid, even if
  // the freeze lands in the middle of a clear pulse.
  assign clear_space = timer_go ? clear_q : 2'b00;
  assign point_total = points_q;
  assign orders      = {1'b0, count_q};
  assign order_times = times_q;

endmodule

// File: tb/tb_order_tracker.sv
// ---------------------------------------------------------------------------
// tb_order_tracker
//
// Self-checking bench for order_tracker. A vector table and a few directed
// sequences cover reset, spawning, delivery, hold-off, expiry and freeze. A
// long randomized run is compared frame by frame against a queue-based
// reference model. A second, fast-ticking instance with a two-deep queue
// covers the dropped-spawn case.
// ---------------------------------------------------------------------------
module tb_order_tracker;

  localparam int FPS      = 60;
  localparam int OTIME    = 30;
  localparam int INTERVAL = 10;
  localparam int MAXO     = 4;
  localparam int BASE     = 20;
  localparam int PEN      = 10;
  localparam int MAXP     = 999;
  localparam int HOLDOFF  = 2;

  logic            vsync = 1'b1;
  logic            reset;
  logic            timer_go;
  logic [1:0][3:0] check_spaces;
  logic [1:0]      clear_space;
  logic [9:0]      point_total;
  logic [3:0]      orders;
  logic [3:0][4:0] order_times;

  // Small instance: 2 frames per second, spawn every 2 seconds, 2 slots.
  logic            reset2 = 1'b1;
  logic            go2    = 1'b1;
  logic [1:0][3:0] cs2    = '0;
  logic [1:0]      clear2;
  logic [9:0]      points2;
  logic [3:0]      orders2;
  logic [3:0][4:0] times2;

  int checks = 0;
  int errors = 0;

  always #5 vsync = ~vsync;

  order_tracker dut (
    .vsync       (vsync),
    .reset       (reset),
    .timer_go    (timer_go),
    .check_spaces(check_spaces),
    .clear_space (clear_space),
    .point_total (point_total),
    .orders      (orders),
    .order_times (order_times)
  );

  order_tracker #(
    .FRAMES_PER_SEC(2),
    .ORDER_INTERVAL(2),
    .MAX_ORDERS    (2)
  ) dut_small (
    .vsync       (vsync),
    .reset       (reset2),
    .timer_go    (go2),
    .check_spaces(cs2),
    .clear_space (clear2),
    .point_total (points2),
    .orders      (orders2),
    .order_times (times2)
  );

  // -------------------------------------------------------------------------
  // Reference model: a queue of remaining seconds, a running frame count and
  // a lockout counter of frames during which deliveries are ignored.
  // -------------------------------------------------------------------------
  int         m_q[$];
  int         m_pts;
  int         m_frames;
  int         m_secs;
  int         m_lock;
  logic [1:0] m_clear;

  task automatic model_step(input logic r, input logic g, input logic [1:0][3:0] c);
    bit sec;
    int pre;
    if (r) begin
      m_q.delete();
      m_pts    = 0;
      m_frames = 0;
      m_secs   = 0;
      m_lock   = 0;
      m_clear  = 2'b00;
    end else if (g) begin
      m_clear  = 2'b00;
      m_frames = m_frames + 1;
      sec      = (m_frames % FPS) == 0;
      if (m_lock > 0) begin
        m_lock = m_lock - 1;
      end else if (m_q.size() > 0 && (c[0] == 4'd7 || c[1] == 4'd7)) begin
        m_clear = (c[0] == 4'd7) ? 2'b01 : 2'b10;
        m_pts   = m_pts + BASE + m_q[0];
        if (m_pts > MAXP) m_pts = MAXP;
        void'(m_q.pop_front());
        m_lock = HOLDOFF;
      end
      if (sec) begin
        m_secs = m_secs + 1;
        pre    = (m_q.size() > 0) ? m_q[0] : -1;
        foreach (m_q[i]) if (m_q[i] > 0) m_q[i] = m_q[i] - 1;
        if (pre == 0) begin
          void'(m_q.pop_front());
          m_pts = (m_pts >= PEN) ? m_pts - PEN : 0;
        end
        if ((m_secs % INTERVAL) == 1 && m_q.size() < MAXO) m_q.push_back(OTIME);
      end
    end
  endtask

  function automatic logic [19:0] m_times();
    logic [3:0][4:0] t;
    t = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < m_q.size()) t[i] = 5'(m_q[i]);
    end
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one frame: inputs change on the rising edge, the DUT updates on the
  // falling edge, outputs are sampled on the following rising edge.
  task automatic frame(input logic r, input logic g, input logic [1:0][3:0] c);
    reset        = r;
    timer_go     = g;
    check_spaces = c;
    @(negedge vsync);
    model_step(r, g, c);
    @(posedge vsync);
  endtask

  task automatic run(input int n, input logic g, input logic [1:0][3:0] c);
    for (int i = 0; i < n; i++) frame(1'b0, g, c);
  endtask

  function automatic logic [1:0][3:0] cells(input logic [3:0] c1, input logic [3:0] c0);
    return {c1, c0};
  endfunction

  // -------------------------------------------------------------------------
  // Vector table
  // -------------------------------------------------------------------------
  typedef struct {
    logic       rst;
    logic       go;
    logic [3:0] cs0;
    logic [3:0] cs1;
    int         n;
    logic [1:0] clr;
    int         pts;
    int         ord;
    int         t0;
    string      name;
  } vec_t;

  vec_t tbl[19];

  initial begin
    logic [1:0][3:0] c;
    logic            g;
    bit              dish_on;

    reset        = 1'b1;
    timer_go     = 1'b1;
    check_spaces = '0;
    @(posedge vsync);

    tbl[0]  = '{1'b1, 1'b1, 4'd0, 4'd0,   1, 2'b00,  0, 0,  0, "reset"};
    tbl[1]  = '{1'b0, 1'b1, 4'd0, 4'd0,  59, 2'b00,  0, 0,  0, "pre_spawn"};
    tbl[2]  = '{1'b0, 1'b1, 4'd0, 4'd0,   1, 2'b00,  0, 1, 30, "first_spawn"};
    tbl[3]  = '{1'b0, 1'b1, 4'd7, 4'd0,   1, 2'b01, 50, 0,  0, "serve_t30"};
    tbl[4]  = '{1'b0, 1'b1, 4'd7, 4'd0,   1, 2'b00, 50, 0,  0, "pulse_one_frame"};
    tbl[5]  = '{1'b0, 1'b1, 4'd7, 4'd0,   4, 2'b00, 50, 0,  0, "dish_no_order"};
    tbl[6]  = '{1'b0, 1'b1, 4'd0, 4'd0, 594, 2'b00, 50, 1, 30, "second_spawn"};
    tbl[7]  = '{1'b0, 1'b1, 4'd0, 4'd0,  60, 2'b00, 50, 1, 29, "one_sec_later"};
    tbl[8]  = '{1'b0, 1'b0, 4'd7, 4'd0, 200, 2'b00, 50, 1, 29, "freeze"};
    tbl[9]  = '{1'b0, 1'b1, 4'd7, 4'd0,   1, 2'b01, 99, 0,  0, "serve_after_freeze"};
    tbl[10] = '{1'b0, 1'b0, 4'd0, 4'd0,   3, 2'b00, 99, 0,  0, "freeze_in_ack"};
    tbl[11] = '{1'b0, 1'b1, 4'd0, 4'd0,   1, 2'b00, 99, 0,  0, "resume"};
    tbl[12] = '{1'b1, 1'b1, 4'd0, 4'd0,   1, 2'b00,  0, 0,  0, "reset_again"};
    tbl[13] = '{1'b0, 1'b1, 4'd0, 4'd0,  60, 2'b00,  0, 1, 30, "respawn"};
    tbl[14] = '{1'b0, 1'b1, 4'd0, 4'd7,   1, 2'b10, 50, 0,  0, "serve_space1"};
    tbl[15] = '{1'b1, 1'b1, 4'd0, 4'd7,   1, 2'b00,  0, 0,  0, "reset_in_ack"};
    tbl[16] = '{1'b0, 1'b1, 4'd0, 4'd7,  59, 2'b00,  0, 0,  0, "dish_after_reset"};
    tbl[17] = '{1'b0, 1'b1, 4'd0, 4'd7,   1, 2'b00,  0, 1, 30, "spawn_after_reset"};
    tbl[18] = '{1'b0, 1'b1, 4'd0, 4'd7,   1, 2'b10, 50, 0,  0, "serve_idle"};

    for (int v = 0; v < 19; v++) begin
      for (int k = 0; k < tbl[v].n; k++) begin
        frame(tbl[v].rst, tbl[v].go, cells(tbl[v].cs1, tbl[v].cs0));
      end
      check({tbl[v].name, ".clear"},  32'(clear_space), 32'(tbl[v].clr));
      check({tbl[v].name, ".points"}, 32'(point_total), 32'(tbl[v].pts));
      check({tbl[v].name, ".orders"}, 32'(orders),      32'(tbl[v].ord));
      check({tbl[v].name, ".t0"},     32'(order_times[0]), 32'(tbl[v].t0));
    end

    // -----------------------------------------------------------------------
    // Both cells hold a dish with two orders queued; the small instance is
    // released from reset alongside and checked for a dropped spawn.
    // -----------------------------------------------------------------------
    reset2 = 1'b1;
    frame(1'b1, 1'b1, '0);
    reset2 = 1'b0;
    run(10, 1'b1, '0);
    check("small.orders_full", 32'(orders2), 32'd2);
    check("small.times",       32'(times2),  32'({5'd0, 5'd0, 5'd28, 5'd26}));
    run(650, 1'b1, '0);
    check("two.orders", 32'(orders),      32'd2);
    check("two.times",  32'(order_times), 32'({5'd0, 5'd0, 5'd30, 5'd20}));
    frame(1'b0, 1'b1, cells(4'd7, 4'd7));
    check("both.first_clear",  32'(clear_space), 32'd1);
    check("both.first_points", 32'(point_total), 32'd40);
    check("both.first_orders", 32'(orders),      32'd1);
    // The action block empties cell 0 in response to the pulse.
    frame(1'b0, 1'b1, cells(4'd7, 4'd0));
    check("both.ack", 32'(clear_space), 32'd0);
    frame(1'b0, 1'b1, cells(4'd7, 4'd0));
    check("both.hold",        32'(clear_space), 32'd0);
    check("both.hold_orders", 32'(orders),      32'd1);
    frame(1'b0, 1'b1, cells(4'd7, 4'd0));
    check("both.second_clear",  32'(clear_space), 32'd2);
    check("both.second_points", 32'(point_total), 32'd90);
    check("both.second_orders", 32'(orders),      32'd0);

    // -----------------------------------------------------------------------
    // Expiry with the score already at zero: the penalty floors at zero.
    // -----------------------------------------------------------------------
    frame(1'b1, 1'b1, '0);
    run(1919, 1'b1, '0);
    check("expiry.before_orders", 32'(orders),      32'd4);
    check("expiry.before_times",  32'(order_times), 32'({5'd30, 5'd20, 5'd10, 5'd0}));
    frame(1'b0, 1'b1, '0);
    check("expiry.orders", 32'(orders),      32'd3);
    check("expiry.floor",  32'(point_total), 32'd0);
    check("expiry.times",  32'(order_times), 32'({5'd0, 5'd29, 5'd19, 5'd9}));

    // -----------------------------------------------------------------------
    // Randomized run against the reference model.
    // -----------------------------------------------------------------------
    frame(1'b1, 1'b1, '0);
    dish_on = 1'b1;
    for (int f = 0; f < 30000; f++) begin
      if ((f % 2500) == 0) dish_on = ($urandom_range(0, 2) != 0);
      g = ($urandom_range(0, 31) != 0);
      for (int s = 0; s < 2; s++) begin
        c[s] = 4'($urandom_range(0, 15));
        if (!dish_on && c[s] == 4'd7) c[s] = 4'd6;
        if (dish_on && $urandom_range(0, 5) == 0) c[s] = 4'd7;
      end
      frame(1'b0, g, c);
      check("rand.clear",  32'(clear_space), 32'(g ? m_clear : 2'b00));
      check("rand.points", 32'(point_total), 32'(m_pts));
      check("rand.orders", 32'(orders),      32'(m_q.size()));
      check("rand.times",  32'(order_times), 32'(m_times()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
